wb_arbiter: RTL and testbench

Write-back arbiter that sits directly upstream of the register file and drives its single write port (A3, WD3, WE3). It merges single-cycle ALU results with variable-latency load results, buffers loads in a 2-entry FIFO, and keeps a 32-bit pending-write scoreboard so decode can stall on RAW hazards against outstanding loads.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_arbiter_if.sv | 46 ++++
 rtl/wb_fifo.sv | 41 ++++
 rtl/wb_arbiter.sv | 106 ++++++++++
 tb/tb_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
// Optional feature macro: WB_BYPASS_EN (adds the fwd1/fwd2 bypass ports).
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int NUM_REGS   = 1 << REG_AW;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus between decode/ALU/LSU and the write-back arbiter.
// Optional feature macro: WB_BYPASS_EN (fwd ports exist only when defined).
interface wb_arbiter_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              iss_valid;
    logic [REG_AW-1:0] iss_rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              stall;
    logic              hold;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
`ifdef WB_BYPASS_EN
    logic              fwd1_en;
    logic              fwd2_en;
    logic [XLEN-1:0]   fwd1_data;
    logic [XLEN-1:0]   fwd2_data;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               iss_valid, iss_rd, rs1, rs2,
`ifdef WB_BYPASS_EN
        output fwd1_en, fwd2_en, fwd1_data, fwd2_data,
`endif
        output mem_ready, stall, hold, wb_we, wb_addr, wb_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               iss_valid, iss_rd, rs1, rs2,
`ifdef WB_BYPASS_EN
        input  fwd1_en, fwd2_en, fwd1_data, fwd2_data,
`endif
        input  mem_ready, stall, hold, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/wb_fifo.sv
// Two-entry load-result buffer; caller guarantees no push when full, no pop when empty.
module wb_fifo
    import wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_wdata,
    output logic      o_full,
    output logic      o_empty,
    output wb_entry_t o_head
);
    wb_entry_t  r_mem [FIFO_DEPTH];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == 2'(FIFO_DEPTH));
    assign o_empty = (r_count == 2'd0);
    assign o_head  = r_mem[r_rptr];
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results beat buffered loads to the single register-file write port,
// with a pending-load scoreboard for RAW stalls. Optional feature macro: WB_BYPASS_EN.
module wb_arbiter
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    logic                w_full;
    logic                w_empty;
    wb_entry_t           w_head;
    wb_entry_t           w_mem_in;
    logic                w_alu_win;
    logic                w_push;
    logic                w_pop;
    logic                w_clr_en;
    logic [REG_AW-1:0]   w_clr_idx;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_set_mask;
    logic                r_we;
    logic                r_from_fifo;
    logic [REG_AW-1:0]   r_addr;
    logic [XLEN-1:0]     r_data;
    logic [NUM_REGS-1:0] r_pending;

    // An ALU write to x0 is a no-op, so it must not block a FIFO pop.
    assign w_alu_win     = bus.alu_valid && (bus.alu_rd != '0);
    assign w_push        = bus.mem_valid && !w_full;
    assign w_pop         = !w_empty && !w_alu_win;
    assign w_mem_in.rd   = bus.mem_rd;
    assign w_mem_in.data = bus.mem_data;

    wb_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_mem_in),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_from_fifo <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else if (w_alu_win) begin
            r_we        <= 1'b1;
            r_from_fifo <= 1'b0;
            r_addr      <= bus.alu_rd;
            r_data      <= bus.alu_data;
        end else if (w_pop) begin
            r_we        <= (w_head.rd != '0);
            r_from_fifo <= 1'b1;
            r_addr      <= w_head.rd;
            r_data      <= w_head.data;
        end else begin
            r_we        <= 1'b0;
            r_from_fifo <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    // Bypass covers the drain cycle, so the pending bit can drop as the pop is selected.
    assign w_clr_en  = w_pop;
    assign w_clr_idx = w_head.rd;
`else
    // No bypass: keep the bit until the register file has actually taken the value.
    assign w_clr_en  = r_we && r_from_fifo;
    assign w_clr_idx = r_addr;
`endif

    assign w_clr_mask = w_clr_en ? (NUM_REGS'(1) << w_clr_idx) : '0;
    assign w_set_mask = bus.iss_valid ? (NUM_REGS'(1) << bus.iss_rd) : '0;

    always_ff @(posedge clk) begin
        if (rst) r_pending <= '0;
        else     r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
    end

`ifdef WB_BYPASS_EN
    logic w_hit1;
    logic w_hit2;
    assign w_hit1        = r_we && (r_addr == bus.rs1) && (bus.rs1 != '0);
    assign w_hit2        = r_we && (r_addr == bus.rs2) && (bus.rs2 != '0);
    assign bus.fwd1_en   = w_hit1;
    assign bus.fwd2_en   = w_hit2;
    assign bus.fwd1_data = r_data;
    assign bus.fwd2_data = r_data;
    assign bus.stall     = ((bus.rs1 != '0) && r_pending[bus.rs1] && !w_hit1) ||
                           ((bus.rs2 != '0) && r_pending[bus.rs2] && !w_hit2);
`else
    assign bus.stall     = ((bus.rs1 != '0) && r_pending[bus.rs1]) ||
                           ((bus.rs2 != '0) && r_pending[bus.rs2]);
`endif

    assign bus.mem_ready = !w_full;
    assign bus.hold      = w_full;
    assign bus.wb_we     = r_we;
    assign bus.wb_addr   = r_addr;
    assign bus.wb_data   = r_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: queue/bitmask model checked every cycle plus literal spot checks.
module tb_wb_arbiter;
    import wb_pkg::*;

    typedef struct {
        bit [4:0]  rd;
        bit [31:0] data;
    } ld_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT write port, used for read-after-write spot checks.
    logic [31:0] rf [32];
    always @(posedge clk) if (bus.wb_we === 1'b1) rf[bus.wb_addr] <= bus.wb_data;

    // Model state.
    ld_t       m_q[$];
    bit [31:0] m_pend;
    bit        m_we, m_ff, m_started;
    bit [4:0]  m_addr;
    bit [31:0] m_data;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_pend = '0; m_we = 0; m_ff = 0; m_addr = '0; m_data = '0;
            m_started = 1;
        end else if (m_started) begin
            automatic bit  push = bus.mem_valid && (m_q.size() < 2);
            automatic ld_t in   = '{bus.mem_rd, bus.mem_data};
            automatic ld_t e;
`ifndef WB_BYPASS_EN
            if (m_we && m_ff) m_pend[m_addr] = 0;
`endif
            if (bus.alu_valid && bus.alu_rd != 0) begin
                m_we = 1; m_ff = 0; m_addr = bus.alu_rd; m_data = bus.alu_data;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_ff = 1;
                m_we = (e.rd != 0);
                if (m_we) begin m_addr = e.rd; m_data = e.data; end
`ifdef WB_BYPASS_EN
                m_pend[e.rd] = 0;
`endif
            end else begin
                m_we = 0; m_ff = 0;
            end
            if (push) m_q.push_back(in);
            if (bus.iss_valid) m_pend[bus.iss_rd] = 1;
            m_pend[0] = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input bit [4:0] rs);
`ifdef WB_BYPASS_EN
        return m_we && m_addr == rs && rs != 0;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (m_started) begin
            automatic bit st = (bus.rs1 != 0 && m_pend[bus.rs1] && !m_hit(bus.rs1)) ||
                               (bus.rs2 != 0 && m_pend[bus.rs2] && !m_hit(bus.rs2));
            chk("cyc_wb_we", 32'(bus.wb_we), 32'(m_we));
            if (m_we) begin
                chk("cyc_wb_addr", 32'(bus.wb_addr), 32'(m_addr));
                chk("cyc_wb_data", bus.wb_data, m_data);
            end
            chk("cyc_mem_ready", 32'(bus.mem_ready), 32'(m_q.size() < 2));
            chk("cyc_hold", 32'(bus.hold), 32'(m_q.size() == 2));
            chk("cyc_stall", 32'(bus.stall), 32'(st));
`ifdef WB_BYPASS_EN
            chk("cyc_fwd1_en", 32'(bus.fwd1_en), 32'(m_hit(bus.rs1)));
            chk("cyc_fwd2_en", 32'(bus.fwd2_en), 32'(m_hit(bus.rs2)));
            if (m_hit(bus.rs1)) chk("cyc_fwd1_data", bus.fwd1_data, m_data);
`endif
            if (!rst && bus.alu_valid && bus.alu_rd != 0 && m_pend[bus.alu_rd]) begin
                failures++;
                $display("FAIL alu_to_pending_reg rd=%0d", bus.alu_rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.iss_valid = 0; bus.iss_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        tick(); tick();
        chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
        chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("rst_hold", 32'(bus.hold), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        rst = 0;

        // ALU write: one cycle to the port, one more into the register file.
        bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        tick();
        bus.alu_valid = 0;
        chk("alu_we", 32'(bus.wb_we), 32'd1);
        chk("alu_addr", 32'(bus.wb_addr), 32'd5);
        chk("alu_data", bus.wb_data, 32'hDEADBEEF);
        tick();
        chk("rf_x5", rf[5], 32'hDEADBEEF);

        // RAW stall on a pending load target, released by the load write-back.
        bus.iss_valid = 1; bus.iss_rd = 5'd7;
        tick();
        bus.iss_valid = 0; bus.rs1 = 5'd7;
        #1 chk("stall_set", 32'(bus.stall), 32'd1);
        bus.mem_valid = 1; bus.mem_rd = 5'd7; bus.mem_data = 32'h1234;
        tick();
        bus.mem_valid = 0;
        chk("ld_not_yet", 32'(bus.wb_we), 32'd0);
        tick();
        chk("ld_we", 32'(bus.wb_we), 32'd1);
        chk("ld_addr", 32'(bus.wb_addr), 32'd7);
        chk("ld_data", bus.wb_data, 32'h1234);
`ifdef WB_BYPASS_EN
        chk("drain_stall", 32'(bus.stall), 32'd0);
        chk("fwd1_en", 32'(bus.fwd1_en), 32'd1);
        chk("fwd1_data", bus.fwd1_data, 32'h1234);
`else
        chk("drain_stall", 32'(bus.stall), 32'd1);
`endif
        tick();
        chk("stall_clr", 32'(bus.stall), 32'd0);
        chk("rf_x7", rf[7], 32'h1234);
        bus.rs1 = '0;

        // Two loads buffered behind continuous ALU traffic.
        bus.alu_valid = 1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA0;
        bus.mem_valid = 1; bus.mem_rd = 5'd3; bus.mem_data = 32'h33;
        tick();
        bus.alu_rd = 5'd11; bus.alu_data = 32'hB0;
        bus.mem_rd = 5'd4; bus.mem_data = 32'h44;
        tick();
        bus.mem_valid = 0; bus.alu_valid = 0;
        chk("full_alu_addr", 32'(bus.wb_addr), 32'd11);
        chk("full_ready", 32'(bus.mem_ready), 32'd0);
        chk("full_hold", 32'(bus.hold), 32'd1);
        tick();
        chk("pop1_addr", 32'(bus.wb_addr), 32'd3);
        chk("pop1_data", bus.wb_data, 32'h33);
        chk("pop1_hold", 32'(bus.hold), 32'd0);
        tick();
        chk("pop2_addr", 32'(bus.wb_addr), 32'd4);
        chk("pop2_data", bus.wb_data, 32'h44);

        // ALU write to x0 lets the FIFO drain; a load to x0 never raises wb_we.
        bus.mem_valid = 1; bus.mem_rd = 5'd12; bus.mem_data = 32'hC;
        tick();
        bus.mem_valid = 0;
        bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
        tick();
        bus.alu_valid = 0;
        chk("x0alu_we", 32'(bus.wb_we), 32'd1);
        chk("x0alu_addr", 32'(bus.wb_addr), 32'd12);
        chk("x0alu_data", bus.wb_data, 32'hC);
        bus.mem_valid = 1; bus.mem_rd = 5'd0; bus.mem_data = 32'h55;
        tick();
        bus.mem_valid = 0;
        tick();
        chk("x0ld_we", 32'(bus.wb_we), 32'd0);

        // Set wins over clear on the same register.
        bus.iss_valid = 1; bus.iss_rd = 5'd9;
        tick();
        bus.iss_valid = 0;
        bus.mem_valid = 1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
        tick();
        bus.mem_valid = 0;
`ifdef WB_BYPASS_EN
        bus.iss_valid = 1; bus.iss_rd = 5'd9;
        tick();
        bus.iss_valid = 0;
        tick();
`else
        tick();
        bus.iss_valid = 1; bus.iss_rd = 5'd9;
        tick();
        bus.iss_valid = 0;
`endif
        bus.rs2 = 5'd9;
        #1 chk("set_wins", 32'(bus.stall), 32'd1);
        bus.rs2 = '0;

        // Reset with a full FIFO and pending bits discards everything.
        bus.iss_valid = 1; bus.iss_rd = 5'd20;
        bus.alu_valid = 1; bus.alu_rd = 5'd13; bus.alu_data = 32'h13;
        bus.mem_valid = 1; bus.mem_rd = 5'd21; bus.mem_data = 32'h21;
        tick();
        bus.iss_valid = 0;
        bus.mem_rd = 5'd22; bus.mem_data = 32'h22;
        tick();
        bus.mem_valid = 0; bus.alu_valid = 0;
        chk("pre_rst_hold", 32'(bus.hold), 32'd1);
        rst = 1;
        tick();
        chk("mid_rst_we", 32'(bus.wb_we), 32'd0);
        chk("mid_rst_addr", 32'(bus.wb_addr), 32'd0);
        chk("mid_rst_data", bus.wb_data, 32'd0);
        chk("mid_rst_ready", 32'(bus.mem_ready), 32'd1);
        chk("mid_rst_hold", 32'(bus.hold), 32'd0);
        rst = 0;
        bus.rs1 = 5'd20; bus.rs2 = 5'd9;
        #1 chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        tick(); tick();
        chk("post_rst_we", 32'(bus.wb_we), 32'd0);
        tick();
        bus.rs1 = '0; bus.rs2 = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
